// File: rtl/counter_pkg.sv
// Shared types and helpers for the multi-channel counter bank.
// Decodes the per-channel mode field, including the reserved encoding.
package counter_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP    = 2'b00,
    CNT_SAT     = 2'b01,
    CNT_ONESHOT = 2'b10
  } cnt_mode_t;

  // Encoding 2'b11 is reserved and behaves exactly like WRAP.
  localparam cnt_mode_t CNT_RESERVED_FALLBACK = CNT_WRAP;

  function automatic cnt_mode_t decode_mode(input logic [1:0] raw);
    cnt_mode_t m;
    case (raw)
      2'b00:   m = CNT_WRAP;
      2'b01:   m = CNT_SAT;
      2'b10:   m = CNT_ONESHOT;
      default: m = CNT_RESERVED_FALLBACK;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One up/down counter channel with clear, clamped load, limit and wrap/saturate/one-shot modes.
// COUNT, TC and DONE are all registered and update on the same edge.
module counter_channel
  import counter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dwn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] STEP_ONE = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_r;
  logic             tc_r;
  logic             done_r;
  logic [WIDTH-1:0] next_count_s;
  logic             next_tc_s;
  logic             next_done_s;
  logic [WIDTH-1:0] inc_s;
  logic [WIDTH-1:0] dec_s;
  cnt_mode_t        mode_s;

  assign mode_s = decode_mode(mode);
  assign inc_s  = count_r + STEP_ONE;
  assign dec_s  = count_r - STEP_ONE;

  // Next-state selection: clear, load, done-hold, step, hold in that priority.
  // Limit comparison happens before the increment, so no value above max_val is produced.
  always_comb begin
    next_count_s = count_r;
    next_tc_s    = 1'b0;
    next_done_s  = done_r;
    if (clr) begin
      next_count_s = '0;
      next_done_s  = 1'b0;
    end else if (load) begin
      next_count_s = (load_val > max_val) ? max_val : load_val;
      next_done_s  = 1'b0;
    end else if (done_r) begin
      next_count_s = count_r;
    end else if (en) begin
      if (up_dwn) begin
        if (count_r < max_val) begin
          next_count_s = inc_s;
          next_tc_s    = (inc_s == max_val);
          next_done_s  = (inc_s == max_val) && (mode_s == CNT_ONESHOT);
        end else if (mode_s == CNT_WRAP) begin
          next_count_s = '0;
        end else begin
          next_count_s = count_r;
        end
      end else begin
        if (count_r != '0) begin
          next_count_s = dec_s;
          next_tc_s    = (dec_s == '0);
          next_done_s  = (dec_s == '0) && (mode_s == CNT_ONESHOT);
        end else if (mode_s == CNT_WRAP) begin
          next_count_s = max_val;
        end else begin
          next_count_s = count_r;
        end
      end
    end else begin
      next_count_s = count_r;
    end
  end

  // Channel state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
      tc_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      count_r <= next_count_s;
      tc_r    <= next_tc_s;
      done_r  <= next_done_s;
    end
  end

  assign count = count_r;
  assign tc    = tc_r;
  assign done  = done_r;

endmodule

// File: rtl/multi_channel_counter.sv
// Bank of NUM_CH independent counter channels sharing one clock and reset.
// This level only slices the packed buses onto per-channel instances.
module multi_channel_counter
  import counter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 16
) (
  input  logic                    CLK,
  input  logic                    N_RST,
  input  logic [NUM_CH-1:0]       EN,
  input  logic [NUM_CH-1:0]       UP_DWN,
  input  logic [NUM_CH-1:0]       CLR,
  input  logic [NUM_CH-1:0]       LOAD,
  input  logic [NUM_CH*WIDTH-1:0] LOAD_VAL,
  input  logic [NUM_CH*WIDTH-1:0] MAX_VAL,
  input  logic [NUM_CH*2-1:0]     MODE,
  output logic [NUM_CH*WIDTH-1:0] COUNT,
  output logic [NUM_CH-1:0]       TC,
  output logic [NUM_CH-1:0]       DONE
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk      (CLK),
      .rst_n    (N_RST),
      .en       (EN[i]),
      .up_dwn   (UP_DWN[i]),
      .clr      (CLR[i]),
      .load     (LOAD[i]),
      .load_val (LOAD_VAL[i*WIDTH +: WIDTH]),
      .max_val  (MAX_VAL[i*WIDTH +: WIDTH]),
      .mode     (MODE[i*2 +: 2]),
      .count    (COUNT[i*WIDTH +: WIDTH]),
      .tc       (TC[i]),
      .done     (DONE[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_counter.sv
// Scoreboard bench for multi_channel_counter with NUM_CH=2, WIDTH=4.
// Expected per-channel results are queued as each cycle is driven and popped after the edge.
module tb_multi_channel_counter;

  localparam int NCH = 2;
  localparam int W   = 4;

  logic           clk;
  logic           n_rst;
  logic [NCH-1:0] en, up_dwn, clr, load;
  logic [NCH*W-1:0] load_val, max_val;
  logic [NCH*2-1:0] mode;
  logic [NCH*W-1:0] count;
  logic [NCH-1:0]   tc, done;

  typedef struct {
    logic [W-1:0] cnt;
    logic         tc;
    logic         done;
  } exp_t;

  exp_t exp_q[$];

  logic [W-1:0] m_cnt [NCH];
  logic         m_tc  [NCH];
  logic         m_done[NCH];

  int n_total = 0;
  int n_bad   = 0;

  multi_channel_counter #(.NUM_CH(NCH), .WIDTH(W)) dut (
    .CLK(clk), .N_RST(n_rst), .EN(en), .UP_DWN(up_dwn), .CLR(clr), .LOAD(load),
    .LOAD_VAL(load_val), .MAX_VAL(max_val), .MODE(mode),
    .COUNT(count), .TC(tc), .DONE(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = '0; m_tc[i] = 1'b0; m_done[i] = 1'b0;
    end
  endtask

  // Behavioural model of one channel for the values driven this cycle.
  task automatic model_step(input int i);
    logic [W-1:0] mv, lv;
    logic [1:0]   md;
    logic         wrap, one;
    mv   = max_val[i*W +: W];
    lv   = load_val[i*W +: W];
    md   = mode[i*2 +: 2];
    wrap = (md == 2'b00) || (md == 2'b11);
    one  = (md == 2'b10);
    m_tc[i] = 1'b0;
    if (clr[i]) begin
      m_cnt[i] = '0; m_done[i] = 1'b0;
    end else if (load[i]) begin
      m_cnt[i] = (lv > mv) ? mv : lv; m_done[i] = 1'b0;
    end else if (!m_done[i] && en[i]) begin
      if (up_dwn[i]) begin
        if (m_cnt[i] < mv) begin
          m_cnt[i]++;
          if (m_cnt[i] == mv) begin m_tc[i] = 1'b1; m_done[i] = one; end
        end else if (wrap) m_cnt[i] = '0;
      end else begin
        if (m_cnt[i] > 0) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin m_tc[i] = 1'b1; m_done[i] = one; end
        end else if (wrap) m_cnt[i] = mv;
      end
    end
  endtask

  task automatic step();
    exp_t e;
    for (int i = 0; i < NCH; i++) begin
      model_step(i);
      e.cnt = m_cnt[i]; e.tc = m_tc[i]; e.done = m_done[i];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      e = exp_q.pop_front();
      chk_eq($sformatf("sb_cnt%0d", i), 32'(count[i*W +: W]), 32'(e.cnt));
      chk_eq($sformatf("sb_tc%0d", i), 32'(tc[i]), 32'(e.tc));
      chk_eq($sformatf("sb_done%0d", i), 32'(done[i]), 32'(e.done));
    end
    @(negedge clk);
  endtask

  initial begin
    int sat_e[5];
    sat_e = '{2, 1, 0, 0, 0};
    n_rst = 1'b0; en = '0; up_dwn = '0; clr = '0; load = '0;
    load_val = '0; max_val = {4'd9, 4'd9}; mode = '0;
    model_reset();
    #12;
    chk_eq("rst_count", 32'(count), 32'd0);
    chk_eq("rst_tc", 32'(tc), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Wrap up on ch0 with limit 9
    en[0] = 1'b1; up_dwn[0] = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      chk_eq("wrap_cnt", 32'(count[3:0]), 32'(k % 10));
      chk_eq("wrap_tc", 32'(tc[0]), 32'((k % 10) == 9));
      chk_eq("wrap_ch1", 32'(count[7:4]), 32'd0);
    end

    // Asynchronous reset in the middle of counting at 5
    clr[0] = 1'b1; step(); clr[0] = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk_eq("pre_rst_cnt", 32'(count[3:0]), 32'd5);
    #2; n_rst = 1'b0; #1;
    chk_eq("mid_rst_count", 32'(count), 32'd0);
    chk_eq("mid_rst_tc", 32'(tc), 32'd0);
    chk_eq("mid_rst_done", 32'(done), 32'd0);
    model_reset();
    @(negedge clk); n_rst = 1'b1;
    step();
    chk_eq("post_rst_cnt", 32'(count[3:0]), 32'd1);

    // Saturate down on ch1 from a load of 3
    en[0] = 1'b0;
    mode[3:2] = 2'b01; load_val[7:4] = 4'd3; load[1] = 1'b1;
    step();
    chk_eq("sat_load", 32'(count[7:4]), 32'd3);
    load[1] = 1'b0; en[1] = 1'b1; up_dwn[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_eq("sat_cnt", 32'(count[7:4]), 32'(sat_e[k]));
      chk_eq("sat_tc", 32'(tc[1]), 32'(k == 2));
    end
    en[1] = 1'b0;

    // One-shot up to 4 on ch0
    mode[1:0] = 2'b10; max_val[3:0] = 4'd4; clr[0] = 1'b1;
    step();
    clr[0] = 1'b0; en[0] = 1'b1; up_dwn[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_eq("os_cnt", 32'(count[3:0]), 32'((k < 4) ? k : 4));
      chk_eq("os_tc", 32'(tc[0]), 32'(k == 4));
      chk_eq("os_done", 32'(done[0]), 32'(k >= 4));
    end
    load_val[3:0] = 4'd1; load[0] = 1'b1;
    step();
    chk_eq("os_reload_cnt", 32'(count[3:0]), 32'd1);
    chk_eq("os_reload_done", 32'(done[0]), 32'd0);

    // Priority: clear beats load and enable; load clamps to the limit
    clr[0] = 1'b1; load_val[3:0] = 4'd7;
    step();
    chk_eq("prio_cnt", 32'(count[3:0]), 32'd0);
    clr[0] = 1'b0; mode[1:0] = 2'b00; max_val[3:0] = 4'd9; load_val[3:0] = 4'd15;
    step();
    chk_eq("clamp_cnt", 32'(count[3:0]), 32'd9);
    chk_eq("clamp_tc", 32'(tc[0]), 32'd0);

    // Independence: ch1 held in clear while ch0 counts; then lower the limit below the count
    load[0] = 1'b0; clr[0] = 1'b1;
    step();
    clr[0] = 1'b0; max_val[3:0] = 4'd12;
    clr[1] = 1'b1; en[1] = 1'b1; up_dwn[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_eq("ind_cnt0", 32'(count[3:0]), 32'(k));
      chk_eq("ind_cnt1", 32'(count[7:4]), 32'd0);
    end
    max_val[3:0] = 4'd5;
    step();
    chk_eq("lim_up_wrap", 32'(count[3:0]), 32'd0);
    max_val[3:0] = 4'd12; load_val[3:0] = 4'd8; load[0] = 1'b1;
    step();
    load[0] = 1'b0; max_val[3:0] = 4'd5; up_dwn[0] = 1'b0;
    step();
    chk_eq("lim_down", 32'(count[3:0]), 32'd7);
    chk_eq("lim_down_tc", 32'(tc[0]), 32'd0);

    // Reserved mode encoding behaves as wrap
    clr[1] = 1'b0; en[1] = 1'b0;
    mode[1:0] = 2'b11; max_val[3:0] = 4'd2; clr[0] = 1'b1;
    step();
    clr[0] = 1'b0; up_dwn[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_eq("rsv_cnt", 32'(count[3:0]), 32'(k % 3));
      chk_eq("rsv_tc", 32'(tc[0]), 32'(k == 2));
    end

    // Zero limit keeps ch1 at zero in both directions
    en[0] = 1'b0; mode[3:2] = 2'b00; max_val[7:4] = 4'd0; en[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      up_dwn[1] = (k < 3);
      step();
      chk_eq("zmax_cnt", 32'(count[7:4]), 32'd0);
      chk_eq("zmax_tc", 32'(tc[1]), 32'd0);
    end

    chk_eq("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
